// File: rtl/trace_field_arbiter.sv
// Round-robin arbiter that serializes one right-justified, null-padded trace
// field at a time onto a character stream, followed by a '|' separator.
module trace_field_arbiter #(
  parameter int NREQ   = 4,
  parameter int NCHARS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_val,
  output logic [NREQ-1:0]          req_rdy,
  input  logic [NREQ*NCHARS*8-1:0] req_msg,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [7:0]               out_char,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
);

  localparam int FW = NCHARS * 8;
  localparam int IW = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] SEP_CHAR = 8'h7C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SEP  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [FW-1:0]     buf_r;
  logic [IW-1:0]     idx_r;
  logic [PW-1:0]     ptr_r;
  logic [PW-1:0]     win_r;
  logic [NREQ-1:0]   grant_r;
  logic              out_val_r;
  logic [7:0]        out_char_r;

  logic              any_s;
  logic [PW-1:0]     win_s;
  logic [NREQ-1:0]   rdy_s;
  logic [FW-1:0]     sel_msg_s;
  logic [IW-1:0]     top_s;
  logic              empty_s;

  // Returns {empty, index of highest non-null byte}; index is 0 for an empty field.
  function automatic logic [IW:0] find_top(input logic [FW-1:0] f);
    logic          found;
    logic [IW-1:0] top;
    found = 1'b0;
    top   = '0;
    for (int i = 0; i < NCHARS; i++) begin
      top   = (f[i*8 +: 8] != 8'h00) ? IW'(i) : top;
      found = found | (f[i*8 +: 8] != 8'h00);
    end
    return {~found, top};
  endfunction

  // Round-robin scan from ptr, wrapping explicitly so any NREQ works.
  always_comb begin : arb_comb
    int cand;
    logic hit;
    cand  = 0;
    hit   = 1'b0;
    any_s = 1'b0;
    win_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand  = int'(ptr_r) + i;
      cand  = (cand >= NREQ) ? (cand - NREQ) : cand;
      hit   = req_val[cand] & ~any_s;
      win_s = hit ? PW'(cand) : win_s;
      any_s = any_s | req_val[cand];
    end
    if (reset && (state_r == ST_IDLE) && any_s) begin
      rdy_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
    end else begin
      rdy_s = '0;
    end
  end

  assign sel_msg_s        = req_msg[int'(win_s)*FW +: FW];
  assign {empty_s, top_s} = find_top(sel_msg_s);

  // Next-state logic; out_val is always high in EMIT/SEP so out_rdy alone means accept.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          state_s = empty_s ? ST_SEP : ST_EMIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (out_rdy && (idx_r == '0)) begin
          state_s = ST_SEP;
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_SEP: begin
        if (out_rdy) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SEP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, capture buffer and registered output character.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      buf_r      <= '0;
      idx_r      <= '0;
      ptr_r      <= '0;
      win_r      <= '0;
      grant_r    <= '0;
      out_val_r  <= 1'b0;
      out_char_r <= 8'h00;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            buf_r      <= sel_msg_s;
            idx_r      <= top_s;
            win_r      <= win_s;
            grant_r    <= rdy_s;
            out_val_r  <= 1'b1;
            out_char_r <= empty_s ? SEP_CHAR : sel_msg_s[int'(top_s)*8 +: 8];
          end
        end
        ST_EMIT: begin
          if (out_rdy) begin
            if (idx_r == '0) begin
              out_char_r <= SEP_CHAR;
            end else begin
              idx_r      <= idx_r - IW'(1);
              out_char_r <= buf_r[(int'(idx_r) - 1)*8 +: 8];
            end
          end
        end
        ST_SEP: begin
          if (out_rdy) begin
            ptr_r      <= (win_r == PW'(NREQ-1)) ? '0 : (win_r + PW'(1));
            grant_r    <= '0;
            out_val_r  <= 1'b0;
            out_char_r <= 8'h00;
          end
        end
        default: begin
          grant_r    <= '0;
          out_val_r  <= 1'b0;
          out_char_r <= 8'h00;
        end
      endcase
    end
  end

  assign req_rdy  = rdy_s;
  assign out_val  = out_val_r;
  assign out_char = out_char_r;
  assign grant    = grant_r;
  assign busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_trace_field_arbiter.sv
// Directed bench for trace_field_arbiter: a 4-requester/16-char instance plus a
// 3-requester/4-char instance for pointer wrap.
module tb_trace_field_arbiter;

  logic          clk;
  logic          reset;
  logic [3:0]    req_val;
  logic [3:0]    req_rdy;
  logic [511:0]  req_msg;
  logic          out_val;
  logic          out_rdy;
  logic [7:0]    out_char;
  logic [3:0]    grant;
  logic          busy;

  logic [2:0]    r3_val;
  logic [2:0]    r3_rdy;
  logic [95:0]   r3_msg;
  logic          r3_oval;
  logic          r3_ordy;
  logic [7:0]    r3_char;
  logic [2:0]    r3_grant;
  logic          r3_busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] acc_q[$];

  trace_field_arbiter #(.NREQ(4), .NCHARS(16)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
    .req_msg(req_msg), .out_val(out_val), .out_rdy(out_rdy),
    .out_char(out_char), .grant(grant), .busy(busy)
  );

  trace_field_arbiter #(.NREQ(3), .NCHARS(4)) dut3 (
    .clk(clk), .reset(reset), .req_val(r3_val), .req_rdy(r3_rdy),
    .req_msg(r3_msg), .out_val(r3_oval), .out_rdy(r3_ordy),
    .out_char(r3_char), .grant(r3_grant), .busy(r3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] fld(input string s);
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < s.len(); i++) f[(s.len()-1-i)*8 +: 8] = s[i];
    return f;
  endfunction

  logic [7:0] rr_chr [12] = '{8'h41, 8'h7C, 8'h00, 8'h43, 8'h7C, 8'h00,
                              8'h41, 8'h7C, 8'h00, 8'h43, 8'h7C, 8'h00};
  logic [3:0] rr_gnt [12] = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000,
                              4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
  logic       bp_rdy [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] bp_chr [7]  = '{8'h78, 8'h79, 8'h79, 8'h79, 8'h7A, 8'h7C, 8'h7C};

  initial begin
    string sxp;
    string sfull;
    reset   = 1'b0;
    req_val = 4'b0000;
    req_msg = '0;
    out_rdy = 1'b1;
    r3_val  = 3'b000;
    r3_msg  = '0;
    r3_ordy = 1'b1;

    // Reset state
    #12;
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_out_char", 32'(out_char), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;

    // Single field "ab" from requester 1
    req_msg[1*128 +: 128] = fld("ab");
    req_val = 4'b0010;
    #1;
    chk("single_req_rdy", 32'(req_rdy), 32'b0010);
    tick();
    req_val = 4'b0000;
    chk("single_c0", 32'(out_char), 32'h61);
    chk("single_v0", 32'(out_val), 32'd1);
    chk("single_g0", 32'(grant), 32'b0010);
    tick();
    chk("single_c1", 32'(out_char), 32'h62);
    chk("single_g1", 32'(grant), 32'b0010);
    tick();
    chk("single_c2", 32'(out_char), 32'h7C);
    chk("single_g2", 32'(grant), 32'b0010);
    tick();
    chk("single_v3", 32'(out_val), 32'd0);
    chk("single_busy3", 32'(busy), 32'd0);
    chk("single_g3", 32'(grant), 32'd0);

    // Round robin between requesters 0 and 2 from reset
    reset = 1'b0;
    req_msg[0*128 +: 128] = fld("A");
    req_msg[2*128 +: 128] = fld("C");
    req_val = 4'b0101;
    #1;
    chk("rr_rdy_in_reset", 32'(req_rdy), 32'd0);
    reset = 1'b1;
    #1;
    chk("rr_rdy0", 32'(req_rdy), 32'b0001);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("rr_val%0d", k), 32'(out_val), (rr_chr[k] != 8'h00) ? 32'd1 : 32'd0);
      chk($sformatf("rr_chr%0d", k), 32'(out_char), 32'(rr_chr[k]));
      chk($sformatf("rr_gnt%0d", k), 32'(grant), 32'(rr_gnt[k]));
    end
    req_val = 4'b0000;

    // Pointer wrap on the 3-requester instance
    r3_msg[2*32 +: 32] = 32'h0000_0043;
    r3_msg[0*32 +: 32] = 32'h0000_0041;
    r3_val = 3'b100;
    #1;
    chk("wrap_rdy_first", 32'(r3_rdy), 32'b100);
    tick();
    r3_val = 3'b000;
    chk("wrap_chr_c", 32'(r3_char), 32'h43);
    tick();
    chk("wrap_chr_sep", 32'(r3_char), 32'h7C);
    tick();
    r3_val = 3'b101;
    #1;
    chk("wrap_rdy_tie", 32'(r3_rdy), 32'b001);
    tick();
    r3_val = 3'b000;
    chk("wrap_chr_a", 32'(r3_char), 32'h41);
    chk("wrap_gnt", 32'(r3_grant), 32'b001);
    tick();
    tick();
    chk("wrap_idle", 32'(r3_oval), 32'd0);

    // Backpressure on "xyz"
    req_msg[1*128 +: 128] = fld("xyz");
    req_val = 4'b0010;
    tick();
    req_val = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      out_rdy = bp_rdy[k];
      chk($sformatf("bp_val%0d", k), 32'(out_val), 32'd1);
      chk($sformatf("bp_chr%0d", k), 32'(out_char), 32'(bp_chr[k]));
      if (out_val && out_rdy) acc_q.push_back(out_char);
      tick();
    end
    out_rdy = 1'b1;
    chk("bp_idle", 32'(out_val), 32'd0);
    chk("bp_count", 32'(acc_q.size()), 32'd4);
    sxp = "xyz|";
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_acc%0d", i), 32'((i < acc_q.size()) ? acc_q[i] : 8'h00), 32'(sxp[i]));
    end

    // Empty field: separator only
    req_msg[2*128 +: 128] = '0;
    req_val = 4'b0100;
    #1;
    chk("empty_rdy", 32'(req_rdy), 32'b0100);
    tick();
    req_val = 4'b0000;
    chk("empty_sep_val", 32'(out_val), 32'd1);
    chk("empty_sep_chr", 32'(out_char), 32'h7C);
    tick();
    chk("empty_idle", 32'(out_val), 32'd0);

    // Full 16-character field
    sfull = "0123456789ABCDEF";
    req_msg[0*128 +: 128] = fld(sfull);
    req_val = 4'b0001;
    tick();
    req_val = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_chr%0d", i), 32'(out_char), 32'(sfull[i]));
      tick();
    end
    chk("full_sep", 32'(out_char), 32'h7C);
    tick();
    chk("full_idle", 32'(out_val), 32'd0);

    // Reset in the middle of "hello"
    req_msg[1*128 +: 128] = fld("hello");
    req_val = 4'b0010;
    tick();
    req_val = 4'b0000;
    chk("hello_h", 32'(out_char), 32'h68);
    tick();
    chk("hello_e", 32'(out_char), 32'h65);
    tick();
    chk("hello_l", 32'(out_char), 32'h6C);
    reset = 1'b0;
    #1;
    chk("midrst_val", 32'(out_val), 32'd0);
    chk("midrst_chr", 32'(out_char), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_gnt", 32'(grant), 32'd0);
    req_msg[3*128 +: 128] = fld("Q");
    req_val = 4'b1000;
    #1;
    chk("midrst_rdy_held", 32'(req_rdy), 32'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(req_rdy), 32'b1000);
    tick();
    req_val = 4'b0000;
    chk("post_rst_chr", 32'(out_char), 32'h51);
    chk("post_rst_gnt", 32'(grant), 32'b1000);
    tick();
    chk("post_rst_sep", 32'(out_char), 32'h7C);
    tick();
    chk("post_rst_idle", 32'(out_val), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
